// File: rtl/dtp_bram_pkg.sv
// Shared constants and types for the BRAM stream reader.
package dtp_bram_pkg;

    localparam int DTP_BRAM_AWIDTH     = 14;
    localparam int DTP_BRAM_DWIDTH     = 32;
    // Word address to byte address: two low zero bits (32-bit words).
    localparam int DTP_BRAM_BYTE_SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } dtp_bram_state_e;

endpackage

// File: rtl/dtp_bram_rd_fifo.sv
// Synchronous FIFO buffering BRAM read data in front of the output stream.
// A read and a write in the same cycle both take effect, even when full.
// Read data is forced to zero while empty so the stream data is clean.
module dtp_bram_rd_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DWIDTH-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic              wr_fire;
    logic              rd_fire;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_en);
    assign rd_data = empty ? '0 : mem[rd_ptr[PW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dtp_bram_reader.sv
// Reads len consecutive 32-bit words from a BRAM starting at base_addr and
// streams them out on a valid/ready interface with m_last on the final word.
// Reads are credit-limited so that in-flight reads plus buffered words never
// exceed the FIFO depth.
// Optional macro DTP_BRAM_READER_STATS_EN enables the backpressure counter
// stall_cnt; without it stall_cnt is tied to zero.
//
// Stream handshake: a word transfers in a cycle where m_valid and m_ready
// are both high; while m_valid=1 and m_ready=0, m_data/m_valid/m_last hold.
module dtp_bram_reader
    import dtp_bram_pkg::*;
#(
    parameter int AWIDTH     = DTP_BRAM_AWIDTH,
    parameter int DWIDTH     = DTP_BRAM_DWIDTH,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                bram_clk,
    input  logic                                bram_rstn,
    input  logic                                start_valid,
    output logic                                start_ready,
    input  logic [AWIDTH-1:0]                   base_addr,
    input  logic [AWIDTH:0]                     len,
    output logic                                busy,
    output logic                                done,
    output logic [DWIDTH-1:0]                   m_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic                                m_last,
    output logic                                bram_en,
    output logic [3:0]                          bram_we,
    output logic [DWIDTH-1:0]                   bram_din,
    output logic [AWIDTH+DTP_BRAM_BYTE_SHIFT-1:0] bram_addr,
    input  logic [DWIDTH-1:0]                   bram_dout,
    output logic [31:0]                         stall_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    dtp_bram_state_e     state_q, state_d;
    logic [AWIDTH-1:0]   addr_q;
    logic [AWIDTH:0]     rem_q;
    logic [AWIDTH:0]     out_rem_q;
    logic [RD_LATENCY-1:0] vld_q;
    logic                zero_done_q;
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         credit_sum;
    logic                fifo_full;
    logic                fifo_empty;
    logic                credit_ok;
    logic                start_fire;
    logic                pop;

    assign bram_we    = '0;
    assign bram_din   = '0;
    assign bram_addr  = {addr_q, {DTP_BRAM_BYTE_SHIFT{1'b0}}};
    assign busy       = (state_q != IDLE);
    assign start_fire = start_valid && start_ready;
    assign m_valid    = !fifo_empty;
    assign pop        = m_valid && m_ready;
    assign m_last     = m_valid && (out_rem_q == (AWIDTH+1)'(1));
    assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
    // A full FIFO already exhausts the credit; the flag is a direct guard.
    assign credit_ok  = !fifo_full && (credit_sum < (CW+1)'(FIFO_DEPTH));

    // Count reads still travelling through the BRAM latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(vld_q[i]);
        end
    end

    // Next-state and command outputs.
    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        bram_en     = 1'b0;
        done        = zero_done_q;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid && (len != '0)) state_d = ISSUE;
            end
            ISSUE: begin
                bram_en = credit_ok;
                if (credit_ok && (rem_q == (AWIDTH+1)'(1))) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && m_last) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, address and word counters.
    always_ff @(posedge bram_clk or negedge bram_rstn) begin
        if (!bram_rstn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            out_rem_q   <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= start_fire && (len == '0);
            if (start_fire) begin
                addr_q    <= base_addr;
                rem_q     <= len;
                out_rem_q <= len;
            end else begin
                if (bram_en) begin
                    addr_q <= addr_q + AWIDTH'(1);
                    rem_q  <= rem_q - (AWIDTH+1)'(1);
                end
                if (pop) out_rem_q <= out_rem_q - (AWIDTH+1)'(1);
            end
        end
    end

    // Latency pipe: the tail bit marks the cycle bram_dout holds a requested word.
    always_ff @(posedge bram_clk or negedge bram_rstn) begin
        if (!bram_rstn) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= bram_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    dtp_bram_rd_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (bram_clk),
        .rst_n   (bram_rstn),
        .wr_en   (vld_q[RD_LATENCY-1]),
        .wr_data (bram_dout),
        .rd_en   (pop),
        .rd_data (m_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef DTP_BRAM_READER_STATS_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where a word waits on m_ready.
    always_ff @(posedge bram_clk or negedge bram_rstn) begin
        if (!bram_rstn) begin
            stall_q <= '0;
        end else if (start_fire) begin
            stall_q <= '0;
        end else if (m_valid && !m_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dtp_bram_reader.sv
// Directed bench for dtp_bram_reader with a two-stage BRAM model.
// Cycle numbers: H is the cycle in which start_valid/start_ready are both
// high; the accepting edge ends cycle H, so reads start in H+1 and, with
// RD_LATENCY=2, the first word is valid in H+4 (RD_LATENCY+1 edges after
// the accepting edge).
module tb_dtp_bram_reader;

    localparam int RD_LAT = 2;
`ifdef DTP_BRAM_READER_STATS_EN
    localparam int EXP_STALL = 10;
`else
    localparam int EXP_STALL = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [13:0] base_addr;
    logic [14:0] len;
    logic        busy;
    logic        done;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_din;
    logic [15:0] bram_addr;
    logic [31:0] bram_dout;
    logic [31:0] stall_cnt;

    dtp_bram_reader #(
        .AWIDTH     (14),
        .DWIDTH     (32),
        .RD_LATENCY (RD_LAT),
        .FIFO_DEPTH (4)
    ) dut (
        .bram_clk    (clk),
        .bram_rstn   (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .base_addr   (base_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_din    (bram_din),
        .bram_addr   (bram_addr),
        .bram_dout   (bram_dout),
        .stall_cnt   (stall_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM contents: word at address a holds a-16, so 0x10..0x17 hold 0..7.
    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return 32'(a) - 32'd16;
    endfunction

    // Two-register BRAM: data for an address seen in cycle c is on dout in c+2.
    logic [31:0] bram_stage;
    always @(posedge clk) begin
        if (bram_en) bram_stage <= mem_word(bram_addr[15:2]);
        bram_dout <= bram_stage;
    end

    // ---------------- monitor ----------------
    logic [15:0] en_addr_q[$];
    int          en_cyc_q[$];
    logic [31:0] out_data_q[$];
    logic        out_last_q[$];
    int          out_cyc_q[$];
    int          done_cyc_q[$];
    int          hs_cyc_q[$];
    int          busy_cycles = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_en) begin
                en_addr_q.push_back(bram_addr);
                en_cyc_q.push_back(cyc);
            end
            if (m_valid && m_ready) begin
                out_data_q.push_back(m_data);
                out_last_q.push_back(m_last);
                out_cyc_q.push_back(cyc);
            end
            if (done) done_cyc_q.push_back(cyc);
            if (start_valid && start_ready) hs_cyc_q.push_back(cyc);
            if (busy) busy_cycles++;
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_err++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int en_b, out_b, done_b, hs_b, busy_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        en_b   = en_addr_q.size();
        out_b  = out_data_q.size();
        done_b = done_cyc_q.size();
        hs_b   = hs_cyc_q.size();
        busy_b = busy_cycles;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [13:0] b, input logic [14:0] l);
        @(posedge clk); #1;
        start_valid = 1'b1;
        base_addr   = b;
        len         = l;
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (done_cyc_q.size() <= done_b && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cyc_q.size() > done_b), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_stream(input string tag, input logic [13:0] base, input int n, input bit timed);
        int h;
        logic [13:0] a;
        h = hs_cyc_q[hs_b];
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem_word(base + 14'(i)));
        chk({tag, "_rd_count"}, 64'(en_addr_q.size() - en_b), 64'(n));
        chk({tag, "_word_count"}, 64'(out_data_q.size() - out_b), 64'(n));
        for (int i = 0; i < n; i++) begin
            a = base + 14'(i);
            chk($sformatf("%s_addr%0d", tag, i), en_addr_q[en_b+i], {a, 2'b00});
            chk($sformatf("%s_data%0d", tag, i), out_data_q[out_b+i], exp_q.pop_front());
            chk($sformatf("%s_last%0d", tag, i), out_last_q[out_b+i], (i == n - 1));
            if (timed) begin
                chk($sformatf("%s_en_cyc%0d", tag, i), en_cyc_q[en_b+i], h + 1 + i);
                chk($sformatf("%s_out_cyc%0d", tag, i), out_cyc_q[out_b+i], h + RD_LAT + 2 + i);
            end
        end
        chk({tag, "_done_cyc"}, done_cyc_q[done_b], out_cyc_q[out_b+n-1]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n       = 1'b1;
        start_valid = 1'b0;
        base_addr   = '0;
        len         = '0;
        m_ready     = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_bram_we", bram_we, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic 8-word read with m_ready held high.
        snap();
        do_start(14'h0010, 15'd8);
        wait_done("s1", 200);
        check_stream("s1", 14'h0010, 8, 1'b1);
        chk("s1_idle_after", busy, 0);

        // Address wrap at the top of the word space.
        snap();
        do_start(14'h3FFE, 15'd4);
        wait_done("s2", 200);
        check_stream("s2", 14'h3FFE, 4, 1'b1);

        // Zero-length command.
        snap();
        do_start(14'h0055, 15'd0);
        wait_done("s3", 20);
        chk("s3_done_cyc", done_cyc_q[done_b], hs_cyc_q[hs_b] + 1);
        repeat (5) @(posedge clk);
        #1;
        chk("s3_no_reads", 64'(en_addr_q.size() - en_b), 64'd0);
        chk("s3_never_busy", 64'(busy_cycles - busy_b), 64'd0);
        chk("s3_one_done", 64'(done_cyc_q.size() - done_b), 64'd1);

        // 16 words with m_ready low for ten cycles while data is waiting.
        snap();
        do_start(14'h0040, 15'd16);
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 m_ready = 1'b1;
        wait_done("s4", 300);
        check_stream("s4", 14'h0040, 16, 1'b0);
        chk("s4_stall_cnt", stall_cnt, EXP_STALL);
        chk("s4_stable_in_stall", stab_err, 0);

        // start_valid pulsed while busy is ignored.
        snap();
        do_start(14'h0020, 15'd6);
        chk("s6_stall_cleared", stall_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        start_valid = 1'b1;
        base_addr   = 14'h0300;
        len         = 15'd3;
        #1;
        chk("s6_ready_low_busy", start_ready, 0);
        chk("s6_busy", busy, 1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        wait_done("s6", 200);
        check_stream("s6", 14'h0020, 6, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("s6_one_handshake", 64'(hs_cyc_q.size() - hs_b), 64'd1);
        chk("s6_no_extra_reads", 64'(en_addr_q.size() - en_b), 64'd6);
        chk("s6_one_done", 64'(done_cyc_q.size() - done_b), 64'd1);

        // Reset during word 5 of a 10-word command, then a fresh command.
        snap();
        do_start(14'h0200, 15'd10);
        n = 0;
        while (out_data_q.size() < out_b + 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("s5_four_words", 64'(out_data_q.size() - out_b), 64'd4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_start_ready", start_ready, 1);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_m_valid", m_valid, 0);
        chk("s5_rst_m_last", m_last, 0);
        chk("s5_rst_m_data", m_data, 0);
        chk("s5_rst_bram_en", bram_en, 0);
        chk("s5_rst_bram_addr", bram_addr, 0);
        chk("s5_rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        snap();
        do_start(14'h0100, 15'd2);
        wait_done("s5", 200);
        check_stream("s5", 14'h0100, 2, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("s5_only_two_words", 64'(out_data_q.size() - out_b), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/dtp_bram_reader.md
DTP_BRAM_READER -- requirements
Module: dtp_bram_reader

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameters SHALL be, one per line:
- AWIDTH, 14, BRAM word-address width.
- DWIDTH, 32, data width.
- RD_LATENCY, 2, BRAM read latency in cycles; legal values 1 or 2.
- FIFO_DEPTH, 4, output buffer depth in words; power of two, at least RD_LATENCY+1.
REQ-003 Ports SHALL be, one per line:
- bram_clk  in  1  clock.
- bram_rstn  in  1  asynchronous active-low reset.
- start_valid  in  1  command request.
- start_ready  out  1  command accepted when high together with start_valid.
- base_addr  in  AWIDTH  first word address.
- len  in  AWIDTH+1  word count; 0 is legal.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- m_data  out  DWIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final word of a command.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM write enables, tied to 0.
- bram_din  out  DWIDTH  BRAM write data, tied to 0.
- bram_addr  out  AWIDTH+2  BRAM byte address, equal to the word address followed by 2'b00.
- bram_dout  in  DWIDTH  BRAM read data.
- stall_cnt  out  32  count of backpressure cycles (see Configuration).

Function
REQ-004 The FSM SHALL have three states: IDLE, ISSUE and DRAIN.
REQ-005 start_ready SHALL be high only in IDLE.
REQ-006 On a start handshake with len>0, the FSM SHALL latch base_addr and len and move to ISSUE.
REQ-007 On a start handshake with len==0, the FSM SHALL stay in IDLE, issue no reads, and pulse done on the next cycle.
REQ-008 In ISSUE, a read SHALL issue (bram_en=1, bram_addr=current word address) in any cycle where in-flight reads plus FIFO occupancy is less than FIFO_DEPTH.
REQ-009 After each issued read, the word address SHALL increment by 1 and wrap modulo 2^AWIDTH.
REQ-010 When the last read issues, the FSM SHALL move to DRAIN.
REQ-011 bram_dout SHALL be captured exactly RD_LATENCY cycles after its issuing cycle, using a RD_LATENCY-deep valid shift register, and written to the FIFO.
REQ-012 The FIFO SHALL never overflow; the credit rule in REQ-008 guarantees this.
REQ-013 The m_* stream SHALL follow the valid/ready rule: m_data, m_valid and m_last stay stable while m_valid=1 and m_ready=0.
REQ-014 A word SHALL be removed from the FIFO when m_valid and m_ready are both high.
REQ-015 m_last SHALL be high only with the len-th word of the command.
REQ-016 In DRAIN, when the last word handshakes, the FSM SHALL pulse done in the same cycle and return to IDLE.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 With m_ready held high, bram_en SHALL be high for len consecutive cycles with no gaps.
REQ-019 With m_ready held high, the first m_valid SHALL occur RD_LATENCY+1 cycles after the start handshake.
REQ-020 A FIFO read and a FIFO write in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-021 start_valid SHALL be ignored while busy=1.

Reset
REQ-022 Assertion of bram_rstn SHALL immediately clear the FSM to IDLE and clear the address, remaining count, in-flight shift register, FIFO pointers and stall_cnt.
REQ-023 In reset, outputs SHALL be: start_ready=1, busy=0, done=0, m_valid=0, m_last=0, m_data=0, bram_en=0, bram_addr=0.
REQ-024 A reset asserted mid-command SHALL abandon the command; BRAM data still in flight at deassertion SHALL be discarded.
REQ-025 Deassertion SHALL be synchronised to bram_clk externally.

Configuration
REQ-026 The macro DTP_BRAM_READER_STATS_EN SHALL control the stall counter.
REQ-027 With DTP_BRAM_READER_STATS_EN defined:
- stall_cnt increments by 1 each cycle with m_valid=1 and m_ready=0.
- stall_cnt saturates at 32'hFFFF_FFFF.
- stall_cnt clears on each accepted start.
REQ-028 Without DTP_BRAM_READER_STATS_EN, stall_cnt SHALL be tied to 0 and no counter logic SHALL be generated.

Structure
REQ-029 Package dtp_bram_pkg SHALL hold:
- the DTP_BRAM_AWIDTH=14 and DWIDTH=32 constants;
- the state enum type {IDLE, ISSUE, DRAIN};
- the byte-address shift constant 2.
REQ-030 A sub-module dtp_bram_rd_fifo SHALL implement a synchronous FIFO with full/empty flags and a count output.
REQ-031 The FSM, address counter and latency pipe SHALL be in dtp_bram_reader.

Verification
REQ-032 Scenario: base=0x0010, len=8, m_ready=1, RD_LATENCY=2 -> bram_addr 0x0040..0x005C on 8 consecutive cycles; data 0..7 in order; first m_valid 3 cycles after start; m_last and done on word 8.
REQ-033 Scenario: base=0x3FFE, len=4 -> word addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001; byte address wraps to 0x0000.
REQ-034 Scenario: len=0 -> no bram_en; done pulses 1 cycle after the handshake; busy stays 0.
REQ-035 Scenario: len=16, m_ready low for cycles 3-12 -> reads stall with no FIFO overflow; all 16 words arrive in order; with STATS_EN, stall_cnt=10.
REQ-036 Scenario: bram_rstn low during word 5 of len=10 -> outputs immediately take reset values; a new command base=0x0100, len=2 returns only its own 2 words.
REQ-037 Scenario: start_valid pulsed while busy -> ignored; start_ready=0; the current command completes unchanged.
